// File: rtl/round_score_tracker_pkg.sv
// Shared game-logic definitions for the round score tracker.
// Holds the FSM state encoding, the default game parameters and the
// result width shared with the upstream 5-bit adder stage.
package round_score_tracker_pkg;

  localparam int RESULT_W        = 5;  // adder result / guess width
  localparam int ROUND_W         = 4;  // round counter width (ROUNDS <= 15)
  localparam int SHOW_CNT_W      = 8;  // show counter width (SHOW_CYCLES <= 255)
  localparam int ROUNDS_DEF      = 8;
  localparam int SHOW_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    CHECK = 3'd2,
    SHOW  = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/round_score_tracker_if.sv
// Bus between the player/adder side and the round score tracker.
//   start, sum_in, sum_valid, guess : requests and operands toward the tracker
//   score, round_num, hit, miss,
//   busy, done                      : game status toward display/LED logic
//   streak_bonus                    : present only when STREAK_BONUS_EN is defined
// Modports: master (stimulus/display side), slave (tracker).
interface round_score_tracker_if #(
  parameter int SCORE_W = 4
);
  import round_score_tracker_pkg::*;

  logic                  start;
  logic [RESULT_W-1:0]   sum_in;
  logic                  sum_valid;
  logic [RESULT_W-1:0]   guess;
  logic [SCORE_W-1:0]    score;
  logic [ROUND_W-1:0]    round_num;
  logic                  hit;
  logic                  miss;
  logic                  busy;
  logic                  done;
`ifdef STREAK_BONUS_EN
  logic                  streak_bonus;
`endif

  modport master (
    output start, sum_in, sum_valid, guess,
    input  score, round_num, hit, miss, busy, done
`ifdef STREAK_BONUS_EN
    , input streak_bonus
`endif
  );

  modport slave (
    input  start, sum_in, sum_valid, guess,
    output score, round_num, hit, miss, busy, done
`ifdef STREAK_BONUS_EN
    , output streak_bonus
`endif
  );

endinterface

// File: rtl/round_score_tracker_sat_score_inc.sv
// Combinational saturating score incrementer.
//   score      : current score
//   inc_two    : add 2 instead of 1
//   score_next : score + (1 or 2), clamped to 2^SCORE_W-1
module sat_score_inc #(
  parameter int SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] score,
  input  logic               inc_two,
  output logic [SCORE_W-1:0] score_next
);

  localparam logic [SCORE_W:0] MAX = {1'b0, {SCORE_W{1'b1}}};

  logic [SCORE_W:0] wide;

  // One extra bit holds any overflow so the clamp can see it.
  always_comb begin
    wide       = {1'b0, score} + (inc_two ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    score_next = (wide > MAX) ? MAX[SCORE_W-1:0] : wide[SCORE_W-1:0];
  end

endmodule

// File: rtl/round_score_tracker.sv
// Round score tracker: latches each adder result with the player's guess,
// scores hits, holds the hit/miss outcome for SHOW_CYCLES cycles and counts
// rounds until game-over.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : round_score_tracker_if.slave (operands in, game status out)
// Optional build macro STREAK_BONUS_EN: a hit after two or more consecutive
// hits adds 2 and raises bus.streak_bonus during SHOW.
module round_score_tracker
  import round_score_tracker_pkg::*;
#(
  parameter int ROUNDS      = ROUNDS_DEF,
  parameter int SHOW_CYCLES = SHOW_CYCLES_DEF,
  parameter int SCORE_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  round_score_tracker_if.slave  bus
);

  localparam logic [ROUND_W-1:0]    ROUNDS_L  = ROUND_W'(ROUNDS);
  localparam logic [SHOW_CNT_W-1:0] SHOW_LOAD = SHOW_CNT_W'(SHOW_CYCLES - 1);

  state_t                state, state_next;
  logic [RESULT_W-1:0]   sum_q, guess_q;
  logic [SCORE_W-1:0]    score_q, score_inc;
  logic [ROUND_W-1:0]    round_q;
  logic [SHOW_CNT_W-1:0] show_cnt;
  logic                  hit_q, miss_q, busy_q, done_q;
  logic                  busy_next, done_next;
  logic                  match, inc_two, game_start;

  assign match      = (guess_q == sum_q);
  assign game_start = bus.start && ((state == IDLE) || (state == OVER));

`ifdef STREAK_BONUS_EN
  logic [1:0] streak_q;
  logic       bonus_q;
  assign inc_two = streak_q[1];  // streak >= 2 before this compare
`else
  assign inc_two = 1'b0;
`endif

  sat_score_inc #(.SCORE_W(SCORE_W)) u_inc (
    .score      (score_q),
    .inc_two    (inc_two),
    .score_next (score_inc)
  );

  // NOTE: state is sequential, so it uses <= ; blocking here would let
  // readers of 'state' in the same edge see the new value.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_next unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start)     state_next = WAIT;
      WAIT:    if (bus.sum_valid) state_next = CHECK;
      CHECK:                      state_next = SHOW;
      SHOW:    if (show_cnt == '0)
                 state_next = ((round_q + ROUND_W'(1)) == ROUNDS_L) ? OVER : WAIT;
      OVER:    if (bus.start)     state_next = WAIT;
      default:                    state_next = IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered, so they
  // line up with the state they describe.
  always_comb begin
    busy_next = (state_next == CHECK) || (state_next == SHOW);
    done_next = (state_next == OVER);
  end

  // NOTE: the operand latches are plain flops, not a memory, so they are
  // cleared on reset like everything else and match stays deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q    <= '0;
      guess_q  <= '0;
      score_q  <= '0;
      round_q  <= '0;
      show_cnt <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q <= '0;
      bonus_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_next;
      done_q <= done_next;

      if (game_start) begin
        score_q <= '0;
        round_q <= '0;
`ifdef STREAK_BONUS_EN
        streak_q <= '0;
`endif
      end

      if ((state == WAIT) && bus.sum_valid) begin
        sum_q   <= bus.sum_in;
        guess_q <= bus.guess;
      end

      if (state == CHECK) begin
        show_cnt <= SHOW_LOAD;
        if (match) begin
          score_q <= score_inc;
          hit_q   <= 1'b1;
        end else begin
          miss_q  <= 1'b1;
        end
`ifdef STREAK_BONUS_EN
        bonus_q  <= match && inc_two;
        // Saturate so long runs keep earning the bonus.
        streak_q <= !match ? 2'd0 : (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
`endif
      end

      if (state == SHOW) begin
        if (show_cnt == '0) begin
          hit_q   <= 1'b0;
          miss_q  <= 1'b0;
          round_q <= round_q + ROUND_W'(1);
`ifdef STREAK_BONUS_EN
          bonus_q <= 1'b0;
`endif
        end else begin
          show_cnt <= show_cnt - SHOW_CNT_W'(1);
        end
      end
    end
  end

  assign bus.score     = score_q;
  assign bus.round_num = round_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef STREAK_BONUS_EN
  assign bus.streak_bonus = bonus_q;
`endif

endmodule

// File: tb/tb_round_score_tracker.sv
// Testbench for round_score_tracker. Two instances share one stimulus
// stream: one with a 4-bit score, one with a 2-bit score (saturation).
// A reference model computes expected outcomes when a round is issued;
// a monitor pops them when the outcome appears on hit/miss.
`timescale 1ns/1ps
module tb_round_score_tracker;
  import round_score_tracker_pkg::*;

  localparam int ROUNDS      = 8;
  localparam int SHOW_CYCLES = 4;
  localparam int SW_A        = 4;
  localparam int SW_S        = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sum_valid = 1'b0;
  logic [4:0] sum_in = '0;
  logic [4:0] guess = '0;

  always #5 clk = ~clk;

  round_score_tracker_if #(.SCORE_W(SW_A)) bus_a ();
  round_score_tracker_if #(.SCORE_W(SW_S)) bus_s ();

  assign bus_a.start = start;  assign bus_s.start = start;
  assign bus_a.sum_valid = sum_valid;  assign bus_s.sum_valid = sum_valid;
  assign bus_a.sum_in = sum_in;  assign bus_s.sum_in = sum_in;
  assign bus_a.guess = guess;  assign bus_s.guess = guess;

  round_score_tracker #(.ROUNDS(ROUNDS), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SW_A))
    u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  round_score_tracker #(.ROUNDS(ROUNDS), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SW_S))
    u_dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {
    int score_a;
    int score_s;
    bit hit;
    bit bonus;
    int round;
    bit over;
    int issue;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  int m_score_a, m_score_s, m_round, m_streak;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_score_a = 0; m_score_s = 0; m_round = 0; m_streak = 0;
  endtask

  task automatic model_round(input bit is_hit);
    exp_t e;
    int inc = 1;
`ifdef STREAK_BONUS_EN
    e.bonus = is_hit && (m_streak >= 2);
    if (e.bonus) inc = 2;
    m_streak = is_hit ? ((m_streak == 3) ? 3 : m_streak + 1) : 0;
`else
    e.bonus = 1'b0;
`endif
    if (is_hit) begin
      m_score_a = sat(m_score_a + inc, SW_A);
      m_score_s = sat(m_score_s + inc, SW_S);
    end
    m_round++;
    e.score_a = m_score_a;
    e.score_s = m_score_s;
    e.hit     = is_hit;
    e.round   = m_round;
    e.over    = (m_round == ROUNDS);
    e.issue   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_score_a"}, bus_a.score, m_score_a);
    check({tag, "_score_s"}, bus_s.score, m_score_s);
    check({tag, "_round_a"}, bus_a.round_num, m_round);
    check({tag, "_round_s"}, bus_s.round_num, m_round);
    check({tag, "_busy"}, bus_a.busy, 0);
    check({tag, "_flags"}, {bus_a.hit, bus_a.miss}, 0);
  endtask

  // Monitor: pops an expectation each time a hit/miss display begins.
  initial begin : monitor
    exp_t cur;
    bit   in_show = 1'b0;
    int   show_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        in_show = 1'b0;
      end else if (!in_show && (bus_a.hit || bus_a.miss)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_show", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          in_show  = 1'b1;
          show_len = 1;
          check("latency", cyc - cur.issue, 2);
          check("hit_a", bus_a.hit, cur.hit);
          check("miss_a", bus_a.miss, !cur.hit);
          check("hit_s", bus_s.hit, cur.hit);
          check("score_a", bus_a.score, cur.score_a);
          check("score_s", bus_s.score, cur.score_s);
          check("busy_show", bus_a.busy, 1);
`ifdef STREAK_BONUS_EN
          check("bonus_a", bus_a.streak_bonus, cur.bonus);
          check("bonus_s", bus_s.streak_bonus, cur.bonus);
`endif
        end
      end else if (in_show) begin
        if (bus_a.hit || bus_a.miss) begin
          show_len++;
          check("hold_flags", {bus_a.hit, bus_a.miss}, {cur.hit, !cur.hit});
        end else begin
          in_show = 1'b0;
          check("show_len", show_len, SHOW_CYCLES);
          check("round_a", bus_a.round_num, cur.round);
          check("round_s", bus_s.round_num, cur.round);
          check("done", bus_a.done, cur.over);
          check("busy_after", bus_a.busy, 0);
          check("score_kept", bus_a.score, cur.score_a);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic start_game();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_reset();
    check("start_state", int'(u_dut_a.state), int'(WAIT));
    check("start_done", bus_a.done, 0);
    check_status("start");
  endtask

  // Issue one round from WAIT and wait for the tracker to leave SHOW.
  // noise: random strobes on sum_valid/start while busy (must be ignored).
  // abort: assert reset once the outcome is showing.
  task automatic play(input logic [4:0] s, input logic [4:0] g,
                      input bit noise, input bit abort);
    bit finished = 1'b0;
    @(negedge clk);
    sum_in = s; guess = g; sum_valid = 1'b1;
    model_round(s == g);
    @(negedge clk);
    sum_valid = 1'b0;
    for (int k = 0; k < SHOW_CYCLES + 10; k++) begin
      if (abort && (bus_a.hit || bus_a.miss)) begin
        sum_valid = 1'b0; start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("rst_state", int'(u_dut_a.state), int'(IDLE));
        check("rst_done", bus_a.done, 0);
        check_status("rst");
        reset = 1'b0;
        return;
      end
      if (!bus_a.busy) begin
        sum_valid = 1'b0; start = 1'b0;
        finished = 1'b1;
        break;
      end
      if (noise) begin
        sum_valid = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        sum_in    = 5'($urandom);
        guess     = 5'($urandom);
      end
      @(negedge clk);
    end
    sum_valid = 1'b0; start = 1'b0;
    if (!finished) check("round_timeout", 0, 1);
  endtask

  function automatic logic [4:0] miss_of(input logic [4:0] s);
    return s ^ 5'($urandom_range(1, 31));
  endfunction

  task automatic play_rand(input bit is_hit, input bit noise);
    logic [4:0] s = 5'($urandom);
    play(s, is_hit ? s : miss_of(s), noise, 1'b0);
  endtask

  task automatic check_over();
    check("over_state", int'(u_dut_a.state), int'(OVER));
    check("over_done_a", bus_a.done, 1);
    check("over_done_s", bus_s.done, 1);
    check_status("over");
  endtask

  initial begin : driver
    model_reset();
    repeat (3) @(negedge clk);
    check("init_state", int'(u_dut_a.state), int'(IDLE));
    check("init_done", bus_a.done, 0);
    check_status("init");
    reset = 1'b0;

    // sum_valid in IDLE is ignored
    @(negedge clk); sum_in = 5'd7; guess = 5'd7; sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0;
    check("idle_ignore", int'(u_dut_a.state), int'(IDLE));

    // Game 1: directed hit, directed miss, then alternating hit/miss
    start_game();
    play(5'd21, 5'd21, 1'b0, 1'b0);
    check("hit_state", int'(u_dut_a.state), int'(WAIT));
    check_status("hit");
    play(5'd31, 5'd30, 1'b1, 1'b0);
    check_status("miss");
    for (int r = 3; r <= ROUNDS; r++) play_rand(r % 2 == 1, 1'b1);
    check("game1_score", bus_a.score, 4);
    check_over();

    // Strobe in OVER changes nothing
    @(negedge clk); sum_in = 5'd3; guess = 5'd3; sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0;
    repeat (SHOW_CYCLES + 2) @(negedge clk);
    check_over();

    // Game 2: five consecutive hits (2-bit score saturates), then random
    start_game();
    for (int r = 0; r < 5; r++) play_rand(1'b1, 1'b0);
    check("sat_score_s", bus_s.score, 3);
    for (int r = 5; r < ROUNDS; r++) play_rand(1'($urandom_range(0, 1)), 1'b1);
    check_over();

    // Game 3: three rounds with two hits, then reset during SHOW
    start_game();
    play(5'd0, 5'd0, 1'b0, 1'b0);
    play(5'd12, 5'd13, 1'b0, 1'b0);
    play(5'd31, 5'd31, 1'b0, 1'b0);
    play(5'd9, 5'd9, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(u_dut_a.state), int'(IDLE));

    // Game 4: fully random rounds with noise
    start_game();
    for (int r = 0; r < ROUNDS; r++) play_rand(1'($urandom_range(0, 1)), 1'b1);
    check_over();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
